// File: rtl/dp_memory_be_pkg.sv
// Shared types and helpers for the byte-enable dual-port memory.
package memory_pkg;

    // Cross-port read-during-write behaviour.
    typedef enum logic {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_e;

    // Clear-sweep controller states.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Number of byte lanes in a word of the given width.
    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/dp_memory_be_if.sv
// One memory access port: request, byte enables, write data and read return.
interface dp_memory_be_if
    import memory_pkg::*;
#(
    parameter int ADDR = 4,
    parameter int DATA = 16
);
    localparam int BYTES = bytes_of(DATA);

    logic             en;
    logic             wr;
    logic [ADDR-1:0]  addr;
    logic [BYTES-1:0] be;
    logic [DATA-1:0]  din;
    logic [DATA-1:0]  dout;
    logic             dout_valid;

    // The requester drives the request and consumes the read return.
    modport master (
        output en, wr, addr, be, din,
        input  dout, dout_valid
    );

    // The memory consumes the request and drives the read return.
    modport slave (
        input  en, wr, addr, be, din,
        output dout, dout_valid
    );

endinterface

// File: rtl/dp_memory_be_rd_pipe.sv
// Read return pipeline: stage 0 captures the array word, later stages add latency.
// The last stage holds its data between valid pulses; flush_n drops everything.
module rd_pipe #(
    parameter int DATA   = 16,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            flush_n,
    input  logic            rd_en,
    input  logic [DATA-1:0] rd_data,
    output logic [DATA-1:0] dout,
    output logic            dout_valid
);

    logic [DATA-1:0] data_reg  [RD_LAT];
    logic            valid_reg [RD_LAT];

    // Shift data and valid together; data only moves when its stage is valid.
    always_ff @(posedge clk) begin
        if (!flush_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                data_reg[i]  <= '0;
                valid_reg[i] <= 1'b0;
            end
        end else begin
            valid_reg[0] <= rd_en;
            if (rd_en) begin
                data_reg[0] <= rd_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                if (valid_reg[i-1]) begin
                    data_reg[i] <= data_reg[i-1];
                end
            end
        end
    end

    assign dout       = data_reg[RD_LAT-1];
    assign dout_valid = valid_reg[RD_LAT-1];

endmodule

// File: rtl/dp_memory_be.sv
// True dual-port RAM with byte enables, pipelined reads, A-wins write collision
// resolution and a zeroing sweep after reset.
module dp_memory_be
    import memory_pkg::*;
#(
    parameter int ADDR     = 4,
    parameter int DATA     = 16,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          ready,
    output logic          collision,
    dp_memory_be_if.slave a,
    dp_memory_be_if.slave b
);

    localparam int  BYTES   = bytes_of(DATA);
    localparam int  DEPTH   = 2 ** ADDR;
    localparam bit  USE_NEW = (RDW_MODE == int'(RDW_NEW));

    logic [DATA-1:0] mem [DEPTH];

    state_e          state_reg, state_next;
    logic [ADDR-1:0] clr_addr_reg, clr_addr_next;
    logic            ready_reg;
    logic            collision_reg;

    logic            a_we, a_re, b_we, b_re, same_addr;
    logic [DATA-1:0] a_new_word, b_new_word, a_rd_data, b_rd_data;

    // Requests only count once the sweep is done and reset is released.
    assign a_we      = rst_n & ready_reg & a.en &  a.wr;
    assign a_re      = rst_n & ready_reg & a.en & ~a.wr;
    assign b_we      = rst_n & ready_reg & b.en &  b.wr;
    assign b_re      = rst_n & ready_reg & b.en & ~b.wr;
    assign same_addr = (a.addr == b.addr);

    // Per-lane view of each port's read word with the other port's same-cycle write applied.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign a_new_word[gi*8 +: 8] = (b_we && same_addr && b.be[gi]) ?
                                           b.din[gi*8 +: 8] : mem[a.addr][gi*8 +: 8];
            assign b_new_word[gi*8 +: 8] = (a_we && same_addr && a.be[gi]) ?
                                           a.din[gi*8 +: 8] : mem[b.addr][gi*8 +: 8];
        end
    endgenerate

    assign a_rd_data = USE_NEW ? a_new_word : mem[a.addr];
    assign b_rd_data = USE_NEW ? b_new_word : mem[b.addr];

    // Array update: sweep zeroing while clearing, otherwise byte-merged writes with A winning shared lanes.
    always_ff @(posedge clk) begin
        if (rst_n && state_reg == CLEAR) begin
            mem[clr_addr_reg] <= '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (a_we && a.be[i]) begin
                    mem[a.addr][i*8 +: 8] <= a.din[i*8 +: 8];
                end
                if (b_we && b.be[i] && !(a_we && same_addr && a.be[i])) begin
                    mem[b.addr][i*8 +: 8] <= b.din[i*8 +: 8];
                end
            end
        end
    end

    // Clear FSM state register; ready follows the registered state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
            ready_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            ready_reg    <= (state_next == READY);
        end
    end

    // Clear FSM next state: walk every address once, then stay READY until reset.
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            CLEAR: begin
                clr_addr_next = clr_addr_reg + ADDR'(1);
                if (clr_addr_reg == ADDR'(DEPTH - 1)) begin
                    state_next = READY;
                end
            end
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    // Collision pulse when both ports write a shared byte lane of one address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= a_we & b_we & same_addr & (|(a.be & b.be));
        end
    end

    assign ready     = ready_reg;
    assign collision = collision_reg;

    rd_pipe #(.DATA(DATA), .RD_LAT(RD_LAT)) u_rd_pipe_a (
        .clk        (clk),
        .flush_n    (rst_n),
        .rd_en      (a_re),
        .rd_data    (a_rd_data),
        .dout       (a.dout),
        .dout_valid (a.dout_valid)
    );

    rd_pipe #(.DATA(DATA), .RD_LAT(RD_LAT)) u_rd_pipe_b (
        .clk        (clk),
        .flush_n    (rst_n),
        .rd_en      (b_re),
        .rd_data    (b_rd_data),
        .dout       (b.dout),
        .dout_valid (b.dout_valid)
    );

endmodule

// File: tb/tb_dp_memory_be.sv
// Bench for dp_memory_be: three instances (RD_LAT=2/old, RD_LAT=1/new, RD_LAT=4/old)
// share one stimulus; a scoreboard holds expected read words with their due cycle.
module tb_dp_memory_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_en, a_wr, b_en, b_wr;
    logic [3:0]  a_addr, b_addr;
    logic [1:0]  a_be, b_be;
    logic [15:0] a_din, b_din;

    dp_memory_be_if #(.ADDR(4), .DATA(16)) ifa[3] ();
    dp_memory_be_if #(.ADDR(4), .DATA(16)) ifb[3] ();

    logic [15:0] dout_k [6];
    logic        vld_k  [6];
    logic        ready_k [3];
    logic        coll_k  [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bind
            assign ifa[gi].en   = a_en;
            assign ifa[gi].wr   = a_wr;
            assign ifa[gi].addr = a_addr;
            assign ifa[gi].be   = a_be;
            assign ifa[gi].din  = a_din;
            assign ifb[gi].en   = b_en;
            assign ifb[gi].wr   = b_wr;
            assign ifb[gi].addr = b_addr;
            assign ifb[gi].be   = b_be;
            assign ifb[gi].din  = b_din;
            assign dout_k[2*gi]   = ifa[gi].dout;
            assign vld_k[2*gi]    = ifa[gi].dout_valid;
            assign dout_k[2*gi+1] = ifb[gi].dout;
            assign vld_k[2*gi+1]  = ifb[gi].dout_valid;
        end
    endgenerate

    dp_memory_be #(.ADDR(4), .DATA(16), .RD_LAT(2), .RDW_MODE(0)) dut_lat2 (
        .clk(clk), .rst_n(rst_n), .ready(ready_k[0]), .collision(coll_k[0]),
        .a(ifa[0]), .b(ifb[0]));
    dp_memory_be #(.ADDR(4), .DATA(16), .RD_LAT(1), .RDW_MODE(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .ready(ready_k[1]), .collision(coll_k[1]),
        .a(ifa[1]), .b(ifb[1]));
    dp_memory_be #(.ADDR(4), .DATA(16), .RD_LAT(4), .RDW_MODE(0)) dut_lat4 (
        .clk(clk), .rst_n(rst_n), .ready(ready_k[2]), .collision(coll_k[2]),
        .a(ifa[2]), .b(ifb[2]));

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sbq [6][$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    // Scoreboard slot k = 2*instance + port; instance 1 is the new-data, latency-1 one.
    function automatic int lat_of(input int k);
        case (k / 2)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 16'h0101) ^ 16'hA50F;
    endfunction

    task automatic set_a(input logic en, input logic wr, input logic [3:0] addr,
                         input logic [1:0] be, input logic [15:0] din);
        a_en = en; a_wr = wr; a_addr = addr; a_be = be; a_din = din;
    endtask

    task automatic set_b(input logic en, input logic wr, input logic [3:0] addr,
                         input logic [1:0] be, input logic [15:0] din);
        b_en = en; b_wr = wr; b_addr = addr; b_be = be; b_din = din;
    endtask

    task automatic idle();
        a_en = 1'b0;
        b_en = 1'b0;
    endtask

    task automatic push_read(input int p, input logic [15:0] old_w, input logic [15:0] new_w);
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            e.data = (d == 1) ? new_w : old_w;
            e.due  = cyc + lat_of(2*d + p);
            sbq[2*d + p].push_back(e);
        end
    endtask

    // Advance one clock and score every read return seen after that edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (vld_k[k] === 1'b1) begin
                n_checks++;
                if (sbq[k].size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_valid slot=%0d cyc=%0d dout=%h required=no valid",
                             k, cyc, dout_k[k]);
                end else begin
                    exp_t e;
                    e = sbq[k].pop_front();
                    if (dout_k[k] !== e.data || cyc != e.due) begin
                        n_errors++;
                        $display("FAIL read_return slot=%0d got=%h@%0d required=%h@%0d",
                                 k, dout_k[k], cyc, e.data, e.due);
                    end
                end
            end else if (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
                exp_t e;
                e = sbq[k].pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL missing_valid slot=%0d cyc=%0d got=no valid required=%h", k, cyc, e.data);
            end
        end
    endtask

    task automatic drain();
        int guard;
        int pending;
        guard = 0;
        pending = 1;
        while (pending != 0 && guard < 8) begin
            step();
            guard++;
            pending = 0;
            for (int k = 0; k < 6; k++) pending += sbq[k].size();
        end
        if (pending != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout got=%0d pending required=0", pending);
            for (int k = 0; k < 6; k++) sbq[k].delete();
        end
    endtask

    task automatic check_collision(input logic want, input string tag);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (coll_k[d] !== want) begin
                n_errors++;
                $display("FAIL %s inst=%0d collision got=%b required=%b", tag, d, coll_k[d], want);
            end
        end
    endtask

    task automatic wait_sweep(input string tag);
        for (int j = 1; j <= 16; j++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (ready_k[d] !== (j == 16)) begin
                    n_errors++;
                    $display("FAIL %s inst=%0d cycle=%0d ready got=%b required=%b",
                             tag, d, j, ready_k[d], (j == 16));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_a(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);
        set_b(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (ready_k[d] !== 1'b0 || coll_k[d] !== 1'b0 || vld_k[2*d] !== 1'b0 ||
                vld_k[2*d+1] !== 1'b0 || dout_k[2*d] !== 16'h0 || dout_k[2*d+1] !== 16'h0) begin
                n_errors++;
                $display("FAIL reset_state inst=%0d got rdy=%b col=%b v=%b%b a=%h b=%h required all 0",
                         d, ready_k[d], coll_k[d], vld_k[2*d], vld_k[2*d+1], dout_k[2*d], dout_k[2*d+1]);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 5) set_a(1'b1, 1'b0, 4'd5, 2'b00, 16'h0000);
            else        idle();
            step();
            if (i >= 5 && i <= 9) begin
                n_checks++;
                if (vld_k[0] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL early_request_valid cycle=%0d got=%b required=0", i, vld_k[0]);
                end
            end
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (ready_k[d] !== (i == 16)) begin
                    n_errors++;
                    $display("FAIL ready_rise inst=%0d cycle=%0d got=%b required=%b",
                             d, i, ready_k[d], (i == 16));
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b0, 4'(i), 2'b00, 16'h0000);
            push_read(0, 16'h0000, 16'h0000);
            step();
        end
        idle();
        drain();
    endtask

    task automatic test_byte_enable();
        set_a(1'b1, 1'b1, 4'd3, 2'b11, 16'hBEEF); step();
        set_a(1'b1, 1'b1, 4'd3, 2'b10, 16'h1200); step();
        set_a(1'b1, 1'b0, 4'd3, 2'b00, 16'h0000); push_read(0, 16'h12EF, 16'h12EF); step();
        set_a(1'b1, 1'b1, 4'd3, 2'b00, 16'hFFFF); step();
        set_a(1'b1, 1'b0, 4'd3, 2'b00, 16'h0000); push_read(0, 16'h12EF, 16'h12EF); step();
        idle();
        drain();
    endtask

    task automatic test_collision();
        set_a(1'b1, 1'b1, 4'd7, 2'b01, 16'hAAAA);
        set_b(1'b1, 1'b1, 4'd7, 2'b11, 16'h5555);
        step();
        check_collision(1'b1, "collision_pulse");
        idle();
        step();
        check_collision(1'b0, "collision_clears");
        set_a(1'b1, 1'b1, 4'd7, 2'b01, 16'hAAAA);
        set_b(1'b1, 1'b1, 4'd8, 2'b11, 16'h5555);
        step();
        check_collision(1'b0, "diff_addr_no_collision");
        set_a(1'b1, 1'b1, 4'd10, 2'b01, 16'h00CC);
        set_b(1'b1, 1'b1, 4'd10, 2'b10, 16'hDD00);
        step();
        check_collision(1'b0, "disjoint_be_no_collision");
        set_a(1'b1, 1'b0, 4'd7, 2'b00, 16'h0000); push_read(0, 16'h55AA, 16'h55AA);
        set_b(1'b1, 1'b0, 4'd8, 2'b00, 16'h0000); push_read(1, 16'h5555, 16'h5555);
        step();
        set_a(1'b1, 1'b0, 4'd10, 2'b00, 16'h0000); push_read(0, 16'hDDCC, 16'hDDCC);
        b_en = 1'b0;
        step();
        idle();
        drain();
    endtask

    task automatic test_rdw();
        set_a(1'b1, 1'b1, 4'd2, 2'b11, 16'h1111); step();
        set_a(1'b1, 1'b1, 4'd2, 2'b11, 16'h2222);
        set_b(1'b1, 1'b0, 4'd2, 2'b00, 16'h0000); push_read(1, 16'h1111, 16'h2222);
        step();
        set_a(1'b1, 1'b0, 4'd2, 2'b00, 16'h0000); push_read(0, 16'h2222, 16'h2233);
        set_b(1'b1, 1'b1, 4'd2, 2'b01, 16'h3333);
        step();
        set_a(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);
        set_b(1'b1, 1'b0, 4'd2, 2'b00, 16'h0000); push_read(1, 16'h2233, 16'h2233);
        step();
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 1'b1, 4'(2*i),     2'b11, pat(2*i));
            set_b(1'b1, 1'b1, 4'(2*i + 1), 2'b11, pat(2*i + 1));
            step();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b0, 4'(i), 2'b00, 16'h0000);
            push_read(0, pat(i), pat(i));
            step();
        end
        idle();
        drain();
        for (int i = 0; i < 6; i++) begin
            set_a(1'b1, 1'b0, 4'(i), 2'b00, 16'h0000);
            push_read(0, pat(i), pat(i));
            step();
        end
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) sbq[k].delete();
        set_a(1'b1, 1'b0, 4'd6, 2'b00, 16'h0000);
        step();
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (ready_k[d] !== 1'b0 || vld_k[2*d] !== 1'b0) begin
                n_errors++;
                $display("FAIL midstream_reset inst=%0d got ready=%b valid=%b required=0/0",
                         d, ready_k[d], vld_k[2*d]);
            end
        end
        rst_n = 1'b1;
        wait_sweep("sweep_restart");
        set_a(1'b1, 1'b0, 4'd5, 2'b00, 16'h0000);
        push_read(0, 16'h0000, 16'h0000);
        step();
        idle();
        drain();
    endtask

    task automatic test_dual_read();
        set_a(1'b1, 1'b1, 4'd9, 2'b11, 16'h0F0F); step();
        set_a(1'b1, 1'b0, 4'd9, 2'b00, 16'h0000); push_read(0, 16'h0F0F, 16'h0F0F);
        set_b(1'b1, 1'b0, 4'd9, 2'b00, 16'h0000); push_read(1, 16'h0F0F, 16'h0F0F);
        step();
        idle();
        check_collision(1'b0, "dual_read_no_collision");
        drain();
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_collision();
        test_rdw();
        test_back_to_back();
        test_dual_read();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
